spi_master_ctrl: RTL and testbench

- SPI master that generates sck/csn/mosi from a single system clock and captures miso. It is the initiator counterpart of the team's SPI slave.
- Frame format matches the slave:
  - sck idles low.
  - Master-to-slave bit is stable across each sck falling edge, where the slave samples it.
  - Slave updates so on each sck rising edge; master samples miso on each falling edge.
  - MSB first, DATA_W bits per frame, csn low for the whole frame.
- Sits between a register/command interface (valid/ready word handshake) and the board-level SPI pins.

---
 rtl/spi_master_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// SPI master: DATA_W-bit frames, MSB first, sck idles low, miso captured on sck falling edges.
// Define SPI_MASTER_LOOPBACK_EN to add a loopback input that samples internal mosi instead of miso.
module spi_master_ctrl #(
  parameter int DATA_W   = 32,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              sck,
  output logic              csn,
  output logic              mosi,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic              loopback,
`endif
  input  logic              miso
);

  localparam int MAX_SH  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int MAX_DI  = (CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE;
  localparam int MAX_CNT = (MAX_SH > MAX_DI) ? MAX_SH : MAX_DI;
  localparam int CNT_W   = $clog2(MAX_CNT);
  localparam int BIT_W   = $clog2(DATA_W + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(CS_IDLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [BIT_W-1:0] BIT_ONE    = BIT_W'(1);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic                sck_q, sck_d;
  logic                csn_q, csn_d;
  logic                mosi_q, mosi_d;
  logic [DATA_W-1:0]   tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0]   rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                accept;
  logic                sample_bit;

`ifdef SPI_MASTER_LOOPBACK_EN
  logic                lb_q, lb_d;
  assign sample_bit = lb_q ? mosi_q : miso;
`else
  assign sample_bit = miso;
`endif

  assign tx_ready = (state_q == IDLE) && !rst;
  assign accept   = tx_valid && tx_ready;
  assign busy     = (state_q != IDLE);
  assign sck      = sck_q;
  assign csn      = csn_q;
  assign mosi     = mosi_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      sck_q      <= 1'b0;
      csn_q      <= 1'b1;
      mosi_q     <= 1'b0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
      lb_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      sck_q      <= sck_d;
      csn_q      <= csn_d;
      mosi_q     <= mosi_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
`ifdef SPI_MASTER_LOOPBACK_EN
      lb_q       <= lb_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    sck_d      = sck_q;
    csn_d      = csn_q;
    mosi_d     = mosi_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
    lb_d       = lb_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          tx_shift_d = tx_data;
          rx_shift_d = '0;
          bit_d      = '0;
          cnt_d      = '0;
          csn_d      = 1'b0;
          mosi_d     = tx_data[DATA_W-1];
          state_d    = SETUP;
`ifdef SPI_MASTER_LOOPBACK_EN
          lb_d       = loopback;
`endif
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = XFER;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      XFER: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          sck_d = ~sck_q;
          if (sck_q) begin
            rx_shift_d = {rx_shift_q[DATA_W-2:0], sample_bit};
            bit_d      = bit_q + BIT_ONE;
            if (bit_q == BIT_LAST) begin
              state_d = HOLD;
            end
          end else if (bit_q != '0) begin
            // Rotate rather than shift so the word is intact; only bit DATA_W-2 is ever driven next.
            tx_shift_d = {tx_shift_q[DATA_W-2:0], tx_shift_q[DATA_W-1]};
            mosi_d     = tx_shift_q[DATA_W-2];
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d      = '0;
          csn_d      = 1'b1;
          mosi_d     = 1'b0;
          rx_data_d  = rx_shift_q;
          rx_valid_d = 1'b1;
          state_d    = GAP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      GAP: begin
        if (cnt_q == IDLE_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: frame-offset timing model, behavioural SPI slave, random frames.
// Define SPI_MASTER_LOOPBACK_EN to also exercise the loopback input.
module tb_spi_master_ctrl;

  localparam int W         = 32;
  localparam int CD        = 4;
  localparam int CSS       = 2;
  localparam int CSH       = 2;
  localparam int CSI       = 2;
  localparam int XFER_LEN  = 2 * CD * W;
  localparam int LOW_LEN   = CSS + XFER_LEN + CSH;
  localparam int FRAME_LEN = 1 + LOW_LEN + CSI;

  logic         clk;
  logic         rst;
  logic         tx_valid;
  logic         tx_ready;
  logic [W-1:0] tx_data;
  logic         rx_valid;
  logic [W-1:0] rx_data;
  logic         busy;
  logic         sck;
  logic         csn;
  logic         mosi;
  logic         miso;
  logic         loopback;

  int n_cmp  = 0;
  int n_fail = 0;

  spi_master_ctrl #(
    .DATA_W(W), .CLK_DIV(CD), .CS_SETUP(CSS), .CS_HOLD(CSH), .CS_IDLE(CSI)
  ) dut (
    .clk(clk), .rst(rst),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy),
    .sck(sck), .csn(csn), .mosi(mosi),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback(loopback),
`endif
    .miso(miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural slave: presents its MSB on each sck rise, shifts mosi in on each sck fall.
  logic [W-1:0] slave_shift;
  logic         tie_miso;
  bit           checking;

  initial begin
    miso = 1'b0;
    wait (checking);
    forever begin
      @(posedge sck);
      miso = tie_miso ? 1'b0 : slave_shift[W-1];
    end
  end

  initial begin
    slave_shift = 32'hDEADBEEF;
    wait (checking);
    forever begin
      @(negedge sck);
      slave_shift = {slave_shift[W-2:0], mosi};
    end
  end

  // Frame model: outputs are a function of the cycle offset t since the accept cycle.
  bit           active;
  int           t;
  int           accepts;
  logic [W-1:0] f_tx, f_rx, exp_rx_data;

  initial begin
    logic e_csn, e_sck, e_mosi, e_rxv, e_busy, e_ready;
    int x, rises, idx;
    active = 0; t = 0; accepts = 0; exp_rx_data = '0; f_tx = '0; f_rx = '0;
    forever begin
      @(negedge clk);
      e_csn = 1'b1; e_sck = 1'b0; e_mosi = 1'b0; e_rxv = 1'b0;
      e_busy = active; e_ready = !active && !rst;
      if (active) begin
        if (t <= LOW_LEN) begin
          e_csn = 1'b0;
          x = t - 1 - CSS;
          if (x >= 0 && x < XFER_LEN) e_sck = ((x / CD) % 2) == 1;
          rises = (x < CD) ? 0 : ((x - CD) / (2 * CD) + 1);
          idx = (rises <= 1) ? (W - 1) : (W - rises);
          e_mosi = f_tx[idx];
        end
        if (t == LOW_LEN + 1) begin
          e_rxv = 1'b1;
          exp_rx_data = f_rx;
        end
      end
      if (checking) begin
        check_output("csn", W'(csn), W'(e_csn));
        check_output("sck", W'(sck), W'(e_sck));
        check_output("mosi", W'(mosi), W'(e_mosi));
        check_output("rx_valid", W'(rx_valid), W'(e_rxv));
        check_output("rx_data", rx_data, exp_rx_data);
        check_output("busy", W'(busy), W'(e_busy));
        check_output("tx_ready", W'(tx_ready), W'(e_ready));
      end
      if (rst) begin
        active = 0;
        exp_rx_data = '0;
      end else if (active) begin
        if (t >= FRAME_LEN - 1) active = 0;
        else t++;
      end else if (tx_valid) begin
        active = 1;
        t = 1;
        accepts++;
        f_tx = tx_data;
        f_rx = slave_shift;
`ifdef SPI_MASTER_LOOPBACK_EN
        if (loopback) f_rx = tx_data;
`endif
      end
    end
  end

  // Pin statistics used by the literal checks.
  int   low_cnt = 0, high_cnt = 0, rise_cnt = 0, fall_cnt = 0;
  int   last_low = 0, last_high = 0, last_rises = 0, rxv_cnt = 0;
  logic prev_sck = 1'b0, prev_csn = 1'b1;

  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        if (csn !== prev_csn) begin
          if (csn) begin
            last_low = low_cnt; last_rises = rise_cnt; high_cnt = 0;
          end else begin
            last_high = high_cnt; low_cnt = 0; rise_cnt = 0; fall_cnt = 0;
          end
        end
        if (csn) high_cnt++; else low_cnt++;
        if (sck && !prev_sck) rise_cnt++;
        if (!sck && prev_sck) fall_cnt++;
        if (rx_valid) rxv_cnt++;
        prev_sck = sck;
        prev_csn = csn;
      end
    end
  end

  task automatic wait_accept(input int target, input int budget);
    int n = 0;
    while (accepts < target && n < budget) begin
      @(posedge clk); #1; n++;
    end
    if (accepts < target) check_output("accept_timeout", W'(accepts), W'(target));
  endtask

  task automatic apply_stimulus(input logic [W-1:0] data);
    int base = accepts;
    @(posedge clk); #1;
    tx_valid = 1'b1;
    tx_data  = data;
    wait_accept(base + 1, 50);
    tx_valid = 1'b0;
    tx_data  = $urandom();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (active && n < FRAME_LEN + 20) begin
      @(posedge clk); #1; n++;
    end
    if (active) check_output("idle_timeout", W'(active), W'(0));
  endtask

  initial begin
    int base, rv;
    rst = 1'b1; tx_valid = 1'b0; tx_data = '0; tie_miso = 1'b0; loopback = 1'b0; checking = 0;

    @(posedge clk); #1;
    checking = 1;
    @(negedge clk);
    check_output("ready_in_rst", W'(tx_ready), W'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_output("ready_after_rst", W'(tx_ready), W'(1));
    check_output("csn_after_rst", W'(csn), W'(1));
    check_output("rx_data_after_rst", rx_data, 32'h0);

    rv = rxv_cnt;
    apply_stimulus(32'h12345678);
    wait_idle();
    check_output("f1_rx_data", rx_data, 32'hDEADBEEF);
    check_output("f1_csn_low", W'(last_low), W'(260));
    check_output("f1_sck_rises", W'(last_rises), W'(32));
    check_output("f1_rx_pulses", W'(rxv_cnt - rv), W'(1));

    apply_stimulus(32'hA5A5A5A5);
    wait_idle();
    check_output("f2_rx_data", rx_data, 32'h12345678);
    check_output("f2_slave_shift", slave_shift, 32'hA5A5A5A5);

    apply_stimulus(32'h80000001);
    @(negedge clk);
    check_output("f3_first_mosi", W'(mosi), W'(1));
    wait_idle();
    check_output("f3_slave_shift", slave_shift, 32'h80000001);
    check_output("f3_rx_data", rx_data, 32'hA5A5A5A5);

    // Three frames with tx_valid held; data changed mid-frame must not disturb the frame in flight.
    base = accepts;
    rv = rxv_cnt;
    @(posedge clk); #1;
    tx_valid = 1'b1;
    tx_data  = $urandom();
    for (int k = 1; k <= 3; k++) begin
      wait_accept(base + k, FRAME_LEN + 20);
      repeat (3) @(posedge clk);
      #1;
      if (k > 1) check_output("b2b_csn_high", W'(last_high), W'(CSI + 1));
      if (k == 3) tx_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      tx_data = $urandom();
    end
    wait_idle();
    check_output("b2b_rx_pulses", W'(rxv_cnt - rv), W'(3));

    // Reset on the 10th sck falling edge of a frame, then a clean frame.
    rv = rxv_cnt;
    apply_stimulus($urandom());
    begin
      int n = 0;
      while (!(fall_cnt == 10 && !csn) && n < FRAME_LEN) begin
        @(posedge clk); #1; n++;
      end
      if (n >= FRAME_LEN) check_output("fall10_timeout", W'(fall_cnt), W'(10));
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_output("mid_rst_csn", W'(csn), W'(1));
    check_output("mid_rst_sck", W'(sck), W'(0));
    check_output("mid_rst_mosi", W'(mosi), W'(0));
    repeat (5) @(posedge clk);
    #1;
    check_output("mid_rst_no_rx", W'(rxv_cnt - rv), W'(0));
    apply_stimulus($urandom());
    wait_idle();
    check_output("post_rst_csn_low", W'(last_low), W'(260));

    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, 6)) @(posedge clk);
      apply_stimulus($urandom());
      wait_idle();
    end

`ifdef SPI_MASTER_LOOPBACK_EN
    @(posedge clk); #1;
    loopback = 1'b1;
    tie_miso = 1'b1;
    apply_stimulus(32'hCAFEF00D);
    wait_idle();
    check_output("loopback_rx", rx_data, 32'hCAFEF00D);
    loopback = 1'b0;
    tie_miso = 1'b0;
`endif

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
